float_to_int_pipe: RTL and testbench
====================================

FLOAT_TO_INT_PIPE -- requirements
Module: float_to_int_pipe

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of clk.
REQ-002 Parameter OUT_W SHALL default to 16 and set the integer result width; the legal range is 2..32.
REQ-003 Parameter SIGNED SHALL default to 1; 1 gives a two's-complement result, 0 gives an unsigned result.
REQ-004 clk  in  1  system clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 a_operand  in  32  IEEE-754 single-precision input.
REQ-007 rnd_mode  in  2  rounding mode, sampled with a_operand: 00 nearest-even, 01 toward zero, 10 toward -inf, 11 toward +inf.
REQ-008 in_valid  in  1  a_operand/rnd_mode valid.
REQ-009 in_ready  out  1  block accepts input this cycle.
REQ-010 result  out  OUT_W  converted integer.
REQ-011 out_valid  out  1  result and flags valid.
REQ-012 out_ready  in  1  downstream accepts result.
REQ-013 flag_invalid  out  1  input was NaN.
REQ-014 flag_overflow  out  1  result was saturated (includes ±inf).
REQ-015 flag_inexact  out  1  rounded value differs from input value, or saturation occurred.

Function
REQ-016 An input SHALL transfer on any cycle where in_valid=1 and in_ready=1; an output SHALL transfer on any cycle where out_valid=1 and out_ready=1.
REQ-017 The pipeline SHALL have two register stages: S1 (unpack, align mantissa, guard/sticky) and S2 (round, negate, saturate, flags). Latency SHALL be 2 cycles from input transfer to out_valid when unstalled.
REQ-018 S2 advances when S2 is empty or out_ready=1; S1 advances when S1 is empty or S2 advances; in_ready SHALL equal the S1-advance term and SHALL be combinational on out_ready.
REQ-019 Sustained throughput SHALL be 1 conversion per cycle while out_ready=1; with out_ready=0, at most 2 transactions are held, and in_ready SHALL be 0 once both stages are full.
REQ-020 Held outputs SHALL stay stable while out_valid=1 and out_ready=0; transaction order SHALL be preserved and no transaction dropped or duplicated.
REQ-021 result SHALL be the exact real value of a_operand rounded per its own rnd_mode, then clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1] (SIGNED=1) or [0, 2^OUT_W-1] (SIGNED=0).
REQ-022 Biased exponent <=126 (including subnormals and ±0) SHALL round correctly (e.g., -subnormal toward -inf gives -1, or 0 with overflow when SIGNED=0); ±0 SHALL give 0 with no flags.
REQ-023 Alignment SHALL use a barrel shift of the 24-bit significand (hidden bit restored) with guard and sticky bits; exponents above 126+OUT_W SHALL saturate without shifter overflow.
REQ-024 NaN SHALL give the maximum positive value with flag_invalid=1, flag_overflow=0, flag_inexact=0.
REQ-025 +inf/-inf SHALL give max/min with flag_overflow=1 and flag_inexact=1.
REQ-026 A rounding carry that crosses the range limit (e.g., 32767.5 nearest-even, OUT_W=16 signed) SHALL saturate and set flag_overflow.
REQ-027 Flags SHALL travel with their result and be valid only when out_valid=1.

Reset
REQ-028 While rst_n=0: out_valid=0, both stage valid bits=0, result=0, all flags=0, in_ready=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight transactions immediately; in_ready SHALL be 1 on the first cycle after rst_n deasserts.

Verification (OUT_W=16, SIGNED=1 unless stated)
REQ-030 0x40490FDB (3.14159), mode 00 -> result 3, inexact=1; 0x3FC00000 (1.5) mode 00 -> 2; 0x40200000 (2.5) mode 00 -> 2, mode 01 -> 2, mode 11 -> 3.
REQ-031 0xC0200000 (-2.5), mode 10 -> 0xFFFD; 0xC7000000 (-32768.0) -> 0x8000, no flags; 0x47000000 (32768.0) -> 0x7FFF, overflow=1.
REQ-032 0x7FC00000 -> 0x7FFF, invalid=1; 0xFF800000 -> 0x8000, overflow=1; SIGNED=0, 0xBF800000 (-1.0) -> 0x0000, overflow=1.
REQ-033 Hold out_ready=0 and offer 4 back-to-back inputs -> 2 accepted, in_ready=0, result held stable; release out_ready -> all 4 results in order, 1 per cycle.
REQ-034 Pulse rst_n low with 2 transactions in flight -> out_valid=0 at once, no stale output after reset; the next input produces a correct result 2 cycles later.
REQ-035 Random sweep with OUT_W in {8,16,32} and all modes -> bit-exact match to a reference model for result and all three flags.

Source files
------------

// File: rtl/float_to_int_pipe.sv
`default_nettype none
// ============================================================================
// Module   : float_to_int_pipe
// Purpose  : Two-stage pipelined IEEE-754 single-precision to integer
//            converter with per-transaction rounding mode, saturation and
//            invalid/overflow/inexact flags. Valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module float_to_int_pipe #(
  parameter int OUT_W  = 16,
  parameter bit SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      a_operand,
  input  logic [1:0]       rnd_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             flag_invalid,
  output logic             flag_overflow,
  output logic             flag_inexact
);

  // Rounding mode encodings
  localparam logic [1:0] c_RNE = 2'b00;
  localparam logic [1:0] c_RTZ = 2'b01;
  localparam logic [1:0] c_RDN = 2'b10;
  localparam logic [1:0] c_RUP = 2'b11;

  // Biased exponent 126 is the value range [0.5,1); anything below is < 0.5.
  localparam logic [7:0] c_HALF_EXP = 8'd126;
  // Above this biased exponent the magnitude is >= 2^OUT_W and always saturates.
  localparam logic [7:0] c_BIG_EXP  = 8'(126 + OUT_W);

  // Range limits of the integer result
  localparam logic [OUT_W-1:0] c_MAXP = SIGNED ? {1'b0, {(OUT_W-1){1'b1}}} : {OUT_W{1'b1}};
  localparam logic [OUT_W-1:0] c_MINV = SIGNED ? {1'b1, {(OUT_W-1){1'b0}}} : {OUT_W{1'b0}};
  // 2^(OUT_W-1) as an (OUT_W+1)-bit magnitude
  localparam logic [OUT_W:0]   c_HALF = {2'b01, {(OUT_W-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic r1_valid;
  logic r2_valid;
  logic w_s2_adv;
  logic w_s1_adv;

  assign w_s2_adv  = ~r2_valid | out_ready;
  assign w_s1_adv  = ~r1_valid | w_s2_adv;
  assign in_ready  = w_s1_adv & rst_n;

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: unpack, classify and align
  // ---------------------------------------------------------------------------
  logic                w_sign;
  logic [7:0]          w_exp;
  logic [22:0]         w_frac;
  logic                w_exp_max;
  logic                w_nan;
  logic                w_sat;
  logic                w_tiny;
  logic [23:0]         w_sig;
  logic [5:0]          w_shamt;
  logic [OUT_W+23:0]   w_aligned;
  logic [OUT_W-1:0]    w_int;
  logic                w_guard;
  logic                w_sticky;

  assign w_sign    = a_operand[31];
  assign w_exp     = a_operand[30:23];
  assign w_frac    = a_operand[22:0];
  assign w_exp_max = &w_exp;
  assign w_nan     = w_exp_max & (|w_frac);
  // Infinity and finite values too large for the shifter both saturate.
  assign w_sat     = (w_exp_max & ~(|w_frac)) | (~w_exp_max & (w_exp > c_BIG_EXP));
  assign w_tiny    = w_exp < c_HALF_EXP;
  assign w_sig     = {|w_exp, w_frac};

  // Shift amount is only meaningful for exponents 126..126+OUT_W (0..OUT_W).
  assign w_shamt   = (w_tiny | w_sat | w_exp_max) ? 6'd0 : 6'(w_exp - c_HALF_EXP);
  // Fixed point with 24 fraction bits: integer part on top, guard at bit 23.
  assign w_aligned = {{OUT_W{1'b0}}, w_sig} << w_shamt;

  // Split the aligned value into integer part, guard and sticky
  always_comb begin
    w_int    = '0;
    w_guard  = 1'b0;
    w_sticky = 1'b0;
    if (w_tiny) begin
      // Magnitude below 0.5: only "nonzero" matters for rounding.
      w_sticky = (|w_exp) | (|w_frac);
    end else if (!(w_sat | w_exp_max)) begin
      w_int    = w_aligned[OUT_W+23:24];
      w_guard  = w_aligned[23];
      w_sticky = |w_aligned[22:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic             r1_sign;
  logic             r1_nan;
  logic             r1_sat;
  logic [OUT_W-1:0] r1_int;
  logic             r1_guard;
  logic             r1_sticky;
  logic [1:0]       r1_mode;

  // Capture a new operand whenever stage 1 is free to move
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid  <= 1'b0;
      r1_sign   <= 1'b0;
      r1_nan    <= 1'b0;
      r1_sat    <= 1'b0;
      r1_int    <= '0;
      r1_guard  <= 1'b0;
      r1_sticky <= 1'b0;
      r1_mode   <= 2'b00;
    end else if (w_s1_adv) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_sign   <= w_sign;
        r1_nan    <= w_nan;
        r1_sat    <= w_sat;
        r1_int    <= w_int;
        r1_guard  <= w_guard;
        r1_sticky <= w_sticky;
        r1_mode   <= rnd_mode;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: round, negate, saturate, flags
  // ---------------------------------------------------------------------------
  logic             w_gs;
  logic             w_inc;
  logic [OUT_W:0]   w_rmag;
  logic [OUT_W-1:0] w_neg;
  logic [OUT_W-1:0] w_res;
  logic             w_inv;
  logic             w_ovf;
  logic             w_inx;

  assign w_gs = r1_guard | r1_sticky;

  // Round-up decision on the magnitude for each mode
  always_comb begin
    w_inc = 1'b0;
    case (r1_mode)
      c_RNE:   w_inc = r1_guard & (r1_sticky | r1_int[0]);
      c_RTZ:   w_inc = 1'b0;
      c_RDN:   w_inc = r1_sign & w_gs;
      c_RUP:   w_inc = ~r1_sign & w_gs;
      default: w_inc = 1'b0;
    endcase
  end

  assign w_rmag = {1'b0, r1_int} + {{OUT_W{1'b0}}, w_inc};
  assign w_neg  = ~w_rmag[OUT_W-1:0] + {{(OUT_W-1){1'b0}}, 1'b1};

  // Apply sign and clamp to the representable range
  always_comb begin
    w_res = '0;
    w_inv = 1'b0;
    w_ovf = 1'b0;
    w_inx = 1'b0;
    if (r1_nan) begin
      w_res = c_MAXP;
      w_inv = 1'b1;
    end else if (r1_sat) begin
      w_res = r1_sign ? c_MINV : c_MAXP;
      w_ovf = 1'b1;
      w_inx = 1'b1;
    end else begin
      if (SIGNED) begin
        if (r1_sign) begin
          if (w_rmag > c_HALF) begin
            w_res = c_MINV;
            w_ovf = 1'b1;
          end else begin
            w_res = w_neg;
          end
        end else if (w_rmag >= c_HALF) begin
          w_res = c_MAXP;
          w_ovf = 1'b1;
        end else begin
          w_res = w_rmag[OUT_W-1:0];
        end
      end else begin
        if (r1_sign) begin
          // Any negative value that rounds to a nonzero magnitude is below 0.
          w_res = '0;
          w_ovf = |w_rmag;
        end else if (w_rmag[OUT_W]) begin
          w_res = c_MAXP;
          w_ovf = 1'b1;
        end else begin
          w_res = w_rmag[OUT_W-1:0];
        end
      end
      w_inx = w_gs | w_ovf;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 registers (drive the outputs directly)
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] r2_result;
  logic             r2_inv;
  logic             r2_ovf;
  logic             r2_inx;

  // Move stage 1 into the output register when downstream allows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid  <= 1'b0;
      r2_result <= '0;
      r2_inv    <= 1'b0;
      r2_ovf    <= 1'b0;
      r2_inx    <= 1'b0;
    end else if (w_s2_adv) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_result <= w_res;
        r2_inv    <= w_inv;
        r2_ovf    <= w_ovf;
        r2_inx    <= w_inx;
      end
    end
  end

  assign out_valid     = r2_valid;
  assign result        = r2_result;
  assign flag_invalid  = r2_inv;
  assign flag_overflow = r2_ovf;
  assign flag_inexact  = r2_inx;

endmodule
`default_nettype wire

// File: tb/tb_float_to_int_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_float_to_int_pipe
// Purpose  : Self-checking bench for float_to_int_pipe. Four instances
//            (16s, 8s, 32s, 16u) share one stimulus stream; a real-arithmetic
//            reference model fills a scoreboard queue on input transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_float_to_int_pipe;

  typedef struct {
    logic [31:0] r;
    logic [2:0]  f;   // {invalid, overflow, inexact}
  } model_t;

  typedef struct {
    logic [31:0]      a;
    logic [1:0]       m;
    logic [3:0][31:0] r;
    logic [3:0][2:0]  f;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [1:0]  m;
    logic [15:0] r;
    logic [2:0]  f;
    bit          use_u;
    logic [15:0] ur;
    logic [2:0]  uf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a_op;
  logic [1:0]  rnd;

  logic [3:0]  ir, ov, fiv, fov, fix;
  logic [15:0] r16, r16u;
  logic [7:0]  r8;
  logic [31:0] r32;

  int ncmp  = 0;
  int nfail = 0;
  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  float_to_int_pipe #(.OUT_W(16), .SIGNED(1)) u16 (
    .clk(clk), .rst_n(rst_n), .a_operand(a_op), .rnd_mode(rnd), .in_valid(in_valid),
    .in_ready(ir[0]), .result(r16), .out_valid(ov[0]), .out_ready(out_ready),
    .flag_invalid(fiv[0]), .flag_overflow(fov[0]), .flag_inexact(fix[0]));
  float_to_int_pipe #(.OUT_W(8), .SIGNED(1)) u8 (
    .clk(clk), .rst_n(rst_n), .a_operand(a_op), .rnd_mode(rnd), .in_valid(in_valid),
    .in_ready(ir[1]), .result(r8), .out_valid(ov[1]), .out_ready(out_ready),
    .flag_invalid(fiv[1]), .flag_overflow(fov[1]), .flag_inexact(fix[1]));
  float_to_int_pipe #(.OUT_W(32), .SIGNED(1)) u32 (
    .clk(clk), .rst_n(rst_n), .a_operand(a_op), .rnd_mode(rnd), .in_valid(in_valid),
    .in_ready(ir[2]), .result(r32), .out_valid(ov[2]), .out_ready(out_ready),
    .flag_invalid(fiv[2]), .flag_overflow(fov[2]), .flag_inexact(fix[2]));
  float_to_int_pipe #(.OUT_W(16), .SIGNED(0)) u16u (
    .clk(clk), .rst_n(rst_n), .a_operand(a_op), .rnd_mode(rnd), .in_valid(in_valid),
    .in_ready(ir[3]), .result(r16u), .out_valid(ov[3]), .out_ready(out_ready),
    .flag_invalid(fiv[3]), .flag_overflow(fov[3]), .flag_inexact(fix[3]));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    ncmp++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  function automatic int cfg_ow(input int k);
    case (k)
      0: return 16;
      1: return 8;
      2: return 32;
      default: return 16;
    endcase
  endfunction

  // Exact value in double precision, then rounding and clamping in longint.
  function automatic model_t model(input logic [31:0] a, input logic [1:0] m,
                                   input int ow, input bit sg);
    model_t      t;
    logic [7:0]  ex;
    logic [22:0] fr;
    real         v, d;
    int          e, mi;
    longint      fl, rl, lo, hi;
    logic [63:0] mask, rb;
    bit          sat;
    ex = a[30:23];
    fr = a[22:0];
    if (sg) begin
      lo = -(longint'(1) <<< (ow - 1));
      hi = (longint'(1) <<< (ow - 1)) - 1;
    end else begin
      lo = 0;
      hi = (longint'(1) <<< ow) - 1;
    end
    mask = (64'd1 << ow) - 64'd1;
    sat  = 1'b0;
    d    = 0.0;
    rl   = 0;
    t.f  = 3'b000;
    if (ex == 8'hFF && fr != 0) begin
      rl  = hi;
      t.f = 3'b100;
    end else if (ex == 8'hFF) begin
      rl  = a[31] ? lo : hi;
      t.f = 3'b011;
    end else begin
      mi = (ex == 8'd0) ? int'(fr) : int'(fr) + 8388608;
      v  = real'(mi);
      e  = (ex == 8'd0) ? -149 : int'(ex) - 150;
      while (e > 0) begin v = v * 2.0; e--; end
      while (e < 0) begin v = v / 2.0; e++; end
      if (a[31]) v = -v;
      if (v >= 1099511627776.0) begin
        rl = hi; sat = 1'b1;
      end else if (v <= -1099511627776.0) begin
        rl = lo; sat = 1'b1;
      end else begin
        fl = longint'(v);
        if (real'(fl) > v) fl = fl - 1;
        d = v - real'(fl);
        case (m)
          2'b00: begin
            if (d > 0.5)      rl = fl + 1;
            else if (d < 0.5) rl = fl;
            else              rl = (fl[0] == 1'b0) ? fl : fl + 1;
          end
          2'b01:   rl = (v < 0.0 && d != 0.0) ? fl + 1 : fl;
          2'b10:   rl = fl;
          default: rl = (d != 0.0) ? fl + 1 : fl;
        endcase
        if (rl < lo)      begin rl = lo; sat = 1'b1; end
        else if (rl > hi) begin rl = hi; sat = 1'b1; end
      end
      t.f = {1'b0, sat, sat | (d != 0.0)};
    end
    rb  = 64'(rl) & mask;
    t.r = rb[31:0];
    return t;
  endfunction

  function automatic exp_t make_exp(input logic [31:0] a, input logic [1:0] m);
    exp_t   e;
    model_t t;
    e.a = a;
    e.m = m;
    for (int k = 0; k < 4; k++) begin
      t      = model(a, m, cfg_ow(k), (k != 3));
      e.r[k] = t.r;
      e.f[k] = t.f;
    end
    return e;
  endfunction

  // Offer one operand until accepted; push its expectation at the accepting edge.
  task automatic send(input exp_t e, input bit rnd_rdy);
    int n    = 0;
    bit done = 1'b0;
    in_valid = 1'b1;
    a_op     = e.a;
    rnd      = e.m;
    while (!done) begin
      @(negedge clk);
      if (ir[0]) begin
        q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      n++;
      if (!done && n > 50) begin
        ncmp++; nfail++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles required acceptance", n);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  // Scoreboard: compare every output transfer against the queue head
  always @(negedge clk) begin
    if (rst_n && ov[0] && out_ready) begin
      if (q.size() == 0) begin
        ncmp++; nfail++;
        $display("FAIL unexpected_output: got out_valid=1 required no pending transaction");
      end else begin
        mon_e = q.pop_front();
        check("lockstep_valid", 64'(ov), 64'hF);
        check("res_w16s", 64'(r16),  64'(mon_e.r[0][15:0]));
        check("flg_w16s", 64'({fiv[0], fov[0], fix[0]}), 64'(mon_e.f[0]));
        check("res_w8s",  64'(r8),   64'(mon_e.r[1][7:0]));
        check("flg_w8s",  64'({fiv[1], fov[1], fix[1]}), 64'(mon_e.f[1]));
        check("res_w32s", 64'(r32),  64'(mon_e.r[2]));
        check("flg_w32s", 64'({fiv[2], fov[2], fix[2]}), 64'(mon_e.f[2]));
        check("res_w16u", 64'(r16u), 64'(mon_e.r[3][15:0]));
        check("flg_w16u", 64'({fiv[3], fov[3], fix[3]}), 64'(mon_e.f[3]));
      end
    end
  end

  vec_t tab [22];
  exp_t sv  [4];
  exp_t e;
  int   idx;
  logic [31:0] ra;

  initial begin
    tab[0]  = '{32'h40490FDB, 2'd0, 16'h0003, 3'b001, 1'b0, 16'h0000, 3'b000};
    tab[1]  = '{32'h3FC00000, 2'd0, 16'h0002, 3'b001, 1'b0, 16'h0000, 3'b000};
    tab[2]  = '{32'h40200000, 2'd0, 16'h0002, 3'b001, 1'b0, 16'h0000, 3'b000};
    tab[3]  = '{32'h40200000, 2'd1, 16'h0002, 3'b001, 1'b0, 16'h0000, 3'b000};
    tab[4]  = '{32'h40200000, 2'd3, 16'h0003, 3'b001, 1'b0, 16'h0000, 3'b000};
    tab[5]  = '{32'hC0200000, 2'd2, 16'hFFFD, 3'b001, 1'b0, 16'h0000, 3'b000};
    tab[6]  = '{32'hC7000000, 2'd0, 16'h8000, 3'b000, 1'b0, 16'h0000, 3'b000};
    tab[7]  = '{32'h47000000, 2'd0, 16'h7FFF, 3'b011, 1'b0, 16'h0000, 3'b000};
    tab[8]  = '{32'h7FC00000, 2'd0, 16'h7FFF, 3'b100, 1'b1, 16'hFFFF, 3'b100};
    tab[9]  = '{32'hFF800000, 2'd0, 16'h8000, 3'b011, 1'b1, 16'h0000, 3'b011};
    tab[10] = '{32'h46FFFF00, 2'd0, 16'h7FFF, 3'b011, 1'b1, 16'h8000, 3'b001};
    tab[11] = '{32'h00000000, 2'd0, 16'h0000, 3'b000, 1'b1, 16'h0000, 3'b000};
    tab[12] = '{32'h80000000, 2'd2, 16'h0000, 3'b000, 1'b1, 16'h0000, 3'b000};
    tab[13] = '{32'h80000001, 2'd2, 16'hFFFF, 3'b001, 1'b1, 16'h0000, 3'b011};
    tab[14] = '{32'h3F000000, 2'd0, 16'h0000, 3'b001, 1'b0, 16'h0000, 3'b000};
    tab[15] = '{32'h3F400000, 2'd0, 16'h0001, 3'b001, 1'b0, 16'h0000, 3'b000};
    tab[16] = '{32'hBF800000, 2'd1, 16'hFFFF, 3'b000, 1'b1, 16'h0000, 3'b011};
    tab[17] = '{32'hC7000080, 2'd2, 16'h8000, 3'b011, 1'b0, 16'h0000, 3'b000};
    tab[18] = '{32'hC7000080, 2'd0, 16'h8000, 3'b001, 1'b0, 16'h0000, 3'b000};
    tab[19] = '{32'h4F000000, 2'd3, 16'h7FFF, 3'b011, 1'b1, 16'hFFFF, 3'b011};
    tab[20] = '{32'h3F7FFFFF, 2'd2, 16'h0000, 3'b001, 1'b0, 16'h0000, 3'b000};
    tab[21] = '{32'hBF7FFFFF, 2'd1, 16'h0000, 3'b001, 1'b1, 16'h0000, 3'b001};

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a_op = '0; rnd = 2'b00;
    #12;
    check("rst_out_valid", 64'(ov), 64'h0);
    check("rst_in_ready",  64'(ir), 64'h0);
    check("rst_result",    64'({r16, r8, r32, r16u}), 64'h0);
    check("rst_flags",     64'({fiv, fov, fix}), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(ir), 64'hF);
    @(posedge clk); #1;

    // Directed table, back-to-back with downstream always ready
    for (int i = 0; i < 22; i++) begin
      e      = make_exp(tab[i].a, tab[i].m);
      e.r[0] = {16'h0000, tab[i].r};
      e.f[0] = tab[i].f;
      if (tab[i].use_u) begin
        e.r[3] = {16'h0000, tab[i].ur};
        e.f[3] = tab[i].uf;
      end
      send(e, 1'b0);
    end

    // Backpressure: 4 offered, 2 held, outputs stable, then a 1-per-cycle burst
    repeat (4) @(posedge clk); #1;
    for (int i = 0; i < 4; i++) sv[i] = make_exp(32'h3F800000 + 32'(i) * 32'h00800000, 2'b00);
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; a_op = sv[idx].a; rnd = sv[idx].m;
      @(negedge clk);
      if (ir[0]) begin q.push_back(sv[idx]); idx++; end
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("stall_accepted", 64'(idx), 64'd2);
    check("stall_in_ready", 64'(ir[0]), 64'd0);
    for (int c = 0; c < 3; c++) begin
      check("stall_out_valid", 64'(ov[0]), 64'd1);
      check("stall_hold", 64'(r16), 64'(q[0].r[0][15:0]));
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin a_op = sv[idx].a; rnd = sv[idx].m; end
      @(negedge clk);
      if (c < 4) check("burst_out_valid", 64'(ov[0]), 64'd1);
      if (in_valid && ir[0]) begin q.push_back(sv[idx]); idx++; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("burst_accepted", 64'(idx), 64'd4);

    // Reset with two transactions in flight
    send(make_exp(32'h40400000, 2'b00), 1'b0);
    send(make_exp(32'h40800000, 2'b00), 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(ov), 64'h0);
    check("midrst_in_ready",  64'(ir), 64'h0);
    check("midrst_result",    64'({r16, r8, r32, r16u}), 64'h0);
    check("midrst_flags",     64'({fiv, fov, fix}), 64'h0);
    q.delete();
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_release_in_ready", 64'(ir[0]), 64'd1);
    check("midrst_no_stale", 64'(ov), 64'h0);
    @(posedge clk); #1;
    in_valid = 1'b1; a_op = 32'h40490FDB; rnd = 2'b00;
    @(negedge clk);
    check("lat_in_ready", 64'(ir[0]), 64'd1);
    if (ir[0]) q.push_back(make_exp(32'h40490FDB, 2'b00));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1_valid", 64'(ov[0]), 64'd0);
    @(negedge clk);
    check("lat_cycle2_valid", 64'(ov[0]), 64'd1);
    @(posedge clk); #1;

    // Random sweep, all modes, random downstream stalls
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0:       ra = $urandom;
        1, 2:    ra = {1'($urandom), 8'($urandom_range(110, 165)), 23'($urandom)};
        3:       ra = {1'($urandom), 8'($urandom_range(120, 132)), 23'($urandom)};
        4:       ra = {1'($urandom), 8'($urandom_range(126, 160)), 23'($urandom) & 23'h7FF000};
        default: begin
          case ($urandom_range(0, 5))
            0:       ra = {1'($urandom), 31'h0};
            1:       ra = {1'($urandom), 8'hFF, 23'h0};
            2:       ra = {1'($urandom), 8'hFF, 23'($urandom) | 23'h1};
            3:       ra = {1'($urandom), 8'h00, 23'($urandom)};
            4:       ra = {1'($urandom), 8'(126 + $urandom_range(0, 2) * 8), 23'h0};
            default: ra = {1'($urandom), 8'(141 + $urandom_range(0, 2)), 23'($urandom) | 23'h7FFF00};
          endcase
        end
      endcase
      send(make_exp(ra, 2'($urandom_range(0, 3))), 1'b1);
    end

    // Drain
    out_ready = 1'b1;
    for (int c = 0; c < 20 && q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    check("drain_empty", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
